// File: rtl/pipe_alu_fwd_if.sv
// Issue, debug-load and result/memory-read signals of the forwarding ALU pipeline.
// The stimulus side drives through master; the pipeline attaches through slave.
interface pipe_alu_fwd_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
);
  logic              in_valid;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [3:0]        func;
  logic [MEM_AW-1:0] addr;
  logic              dbg_we;
  logic [REG_AW-1:0] dbg_waddr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [MEM_AW-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] zout;
  logic [MEM_AW-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, rs1, rs2, rd, func, addr,
    output dbg_we, dbg_waddr, dbg_wdata, mem_raddr,
    input  mem_rdata, out_valid, zout, out_addr, out_err
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, func, addr,
    input  dbg_we, dbg_waddr, dbg_wdata, mem_raddr,
    output mem_rdata, out_valid, zout, out_addr, out_err
  );
endinterface

// File: rtl/pipe_alu_fwd.sv
// Four-stage fetch / execute / write-back / memory ALU pipeline with full operand
// forwarding, illegal-function detection, debug register load and memory read port.
module pipe_alu_fwd #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) (
  input logic           clk,
  input logic           rst,
  pipe_alu_fwd_if.slave bus
);
  localparam int NREG   = 1 << REG_AW;
  localparam int NMEM   = 1 << MEM_AW;
  localparam int STAGES = 3;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_MUL  = 4'd2;
  localparam logic [3:0] F_PASA = 4'd3;
  localparam logic [3:0] F_PASB = 4'd4;
  localparam logic [3:0] F_AND  = 4'd5;
  localparam logic [3:0] F_OR   = 4'd6;
  localparam logic [3:0] F_XOR  = 4'd7;
  localparam logic [3:0] F_NEGA = 4'd8;
  localparam logic [3:0] F_NEGB = 4'd9;
  localparam logic [3:0] F_SHR  = 4'd10;
  localparam logic [3:0] F_SHL  = 4'd11;

  // r_vld_pipe[k] is the valid bit of the instruction held in stage k
  logic [STAGES:1]   r_vld_pipe;

  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [REG_AW-1:0] r_s1_rd;
  logic [3:0]        r_s1_func;
  logic [MEM_AW-1:0] r_s1_addr;

  logic [DATA_W-1:0] r_s2_z;
  logic [REG_AW-1:0] r_s2_rd;
  logic [MEM_AW-1:0] r_s2_addr;
  logic              r_s2_err;

  logic [DATA_W-1:0] r_s3_z;
  logic [MEM_AW-1:0] r_s3_addr;
  logic              r_s3_err;

  logic [DATA_W-1:0] r_regbank [NREG];
  logic [DATA_W-1:0] r_mem     [NMEM];

  logic [DATA_W-1:0]            w_alu_z;
  logic                         w_alu_err;
  logic [1:0][REG_AW-1:0]       w_rs;
  logic [1:0][DATA_W-1:0]       w_op;
  logic                         w_ex_fwd_ok;
  logic                         w_wb_fwd_ok;
  logic                         w_rb_we;
  logic                         w_mem_we;

  // Execute: operates only on the func staged with the instruction
  always_comb begin
    w_alu_z   = '0;
    w_alu_err = 1'b0;
    case (r_s1_func)
      F_ADD:   w_alu_z = r_s1_a + r_s1_b;
      F_SUB:   w_alu_z = r_s1_b - r_s1_a;
      F_MUL:   w_alu_z = r_s1_a * r_s1_b;
      F_PASA:  w_alu_z = r_s1_a;
      F_PASB:  w_alu_z = r_s1_b;
      F_AND:   w_alu_z = r_s1_a & r_s1_b;
      F_OR:    w_alu_z = r_s1_a | r_s1_b;
      F_XOR:   w_alu_z = r_s1_a ^ r_s1_b;
      F_NEGA:  w_alu_z = -r_s1_a;
      F_NEGB:  w_alu_z = -r_s1_b;
      F_SHR:   w_alu_z = r_s1_a >> 1;
      F_SHL:   w_alu_z = r_s1_a << 1;
      default: w_alu_err = 1'b1;
    endcase
  end

  // Forwarding: the instruction in execute is newer than the one in write-back
  assign w_rs        = {bus.rs2, bus.rs1};
  assign w_ex_fwd_ok = r_vld_pipe[1] && !w_alu_err;
  assign w_wb_fwd_ok = r_vld_pipe[2] && !r_s2_err;

  always_comb begin
    w_op = '0;
    for (int i = 0; i < 2; i++) begin
      if (w_ex_fwd_ok && (r_s1_rd == w_rs[i]))
        w_op[i] = w_alu_z;
      else if (w_wb_fwd_ok && (r_s2_rd == w_rs[i]))
        w_op[i] = r_s2_z;
      else
        w_op[i] = r_regbank[w_rs[i]];
    end
  end

  // Valid chain and architecturally visible S3 outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s3_z     <= '0;
      r_s3_addr  <= '0;
      r_s3_err   <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.in_valid};
      r_s3_z     <= r_s2_z;
      r_s3_addr  <= r_s2_addr;
      r_s3_err   <= r_s2_err;
    end
  end

  // Data payload of S1/S2 is qualified by r_vld_pipe, so it needs no reset
  always_ff @(posedge clk) begin
    r_s1_a    <= w_op[0];
    r_s1_b    <= w_op[1];
    r_s1_rd   <= bus.rd;
    r_s1_func <= bus.func;
    r_s1_addr <= bus.addr;
    r_s2_z    <= w_alu_z;
    r_s2_rd   <= r_s1_rd;
    r_s2_addr <= r_s1_addr;
    r_s2_err  <= w_alu_err;
  end

  // Register bank: write-back is issued after the debug write so it wins a collision
  assign w_rb_we = r_vld_pipe[2] && !r_s2_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) r_regbank[k] <= '0;
    end else begin
      if (bus.dbg_we) r_regbank[bus.dbg_waddr] <= bus.dbg_wdata;
      if (w_rb_we)    r_regbank[r_s2_rd]       <= r_s2_z;
    end
  end

  // Memory keeps its contents through reset; only the in-flight write is dropped
  assign w_mem_we = !rst && r_vld_pipe[3] && !r_s3_err;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_s3_addr] <= r_s3_z;
  end

  assign bus.mem_rdata = r_mem[bus.mem_raddr];
  assign bus.out_valid = r_vld_pipe[3];
  assign bus.zout      = r_s3_z;
  assign bus.out_addr  = r_s3_addr;
  assign bus.out_err   = r_s3_err;
endmodule
